id_ex_stage: RTL and testbench

//  ID/EX pipeline stage of the 5-stage MIPS-subset CPU. Registers decoded operands and control from ID,
//  and drives the EX-stage ALU operands (data1/data2) and ALUCtrl.

---
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS-subset core.
// Holds the decoded operands and control for the instruction in EX. Resolves
// EX/MEM and MEM/WB forwarding onto the ALU operands, and raises a load-use
// stall that also turns the next capture into a bubble.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              alu_src_i,
    input  logic [2:0]        alu_ctrl_i,
    input  logic              reg_dst_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    input  logic              exmem_reg_write_i,
    input  logic [ADDR_W-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_reg_write_i,
    input  logic [ADDR_W-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [2:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o,
    output logic              hazard_stall_o
);

    // All registered EX-stage fields; an all-zero value is a bubble (no side effects).
    typedef struct packed {
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rs_addr;
        logic [ADDR_W-1:0] rt_addr;
        logic [ADDR_W-1:0] wr_addr;
        logic              alu_src;
        logic [2:0]        alu_ctrl;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

    id_ex_t stage_d;
    id_ex_t stage_q;

    logic              hazard_stall;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Load-use detection: a load in EX whose target is read by the instruction in ID.
    // rt is always compared, even when ID holds an I-type op that ignores it.
    always_comb begin
        hazard_stall = 1'b0;
        if (stage_q.mem_read && (stage_q.wr_addr != '0) &&
            ((stage_q.wr_addr == rs_addr_i) || (stage_q.wr_addr == rt_addr_i))) begin
            hazard_stall = 1'b1;
        end
    end

    // Next-state selection: freeze beats bubble beats normal capture.
    always_comb begin
        stage_d = stage_q;
        if (stall_i) begin
            stage_d = stage_q;
        end else if (flush_i || hazard_stall) begin
            stage_d = '0;
        end else begin
            stage_d.rs_data    = rs_data_i;
            stage_d.rt_data    = rt_data_i;
            stage_d.imm        = imm_i;
            stage_d.rs_addr    = rs_addr_i;
            stage_d.rt_addr    = rt_addr_i;
            stage_d.wr_addr    = reg_dst_i ? rd_addr_i : rt_addr_i;
            stage_d.alu_src    = alu_src_i;
            stage_d.alu_ctrl   = alu_ctrl_i;
            stage_d.reg_write  = reg_write_i;
            stage_d.mem_read   = mem_read_i;
            stage_d.mem_write  = mem_write_i;
            stage_d.mem_to_reg = mem_to_reg_i;
        end
    end

    // Pipeline register; reset discards any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Operand forwarding: the younger EX/MEM result wins; $0 is never forwarded.
    always_comb begin
        fwd_rs = stage_q.rs_data;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rs_addr)) begin
            fwd_rs = exmem_data_i;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rs_addr)) begin
            fwd_rs = memwb_data_i;
        end

        fwd_rt = stage_q.rt_data;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rt_addr)) begin
            fwd_rt = exmem_data_i;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rt_addr)) begin
            fwd_rt = memwb_data_i;
        end
    end

    assign alu_data1_o    = fwd_rs;
    assign alu_data2_o    = stage_q.alu_src ? stage_q.imm : fwd_rt;
    assign store_data_o   = fwd_rt;
    assign alu_ctrl_o     = stage_q.alu_ctrl;
    assign wr_addr_o      = stage_q.wr_addr;
    assign reg_write_o    = stage_q.reg_write;
    assign mem_read_o     = stage_q.mem_read;
    assign mem_write_o    = stage_q.mem_write;
    assign mem_to_reg_o   = stage_q.mem_to_reg;
    assign hazard_stall_o = hazard_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: capture, forwarding, $0 handling, load-use bubble,
// freeze/flush priority, immediate operand and asynchronous reset.
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OUT_W  = 3 * DATA_W + 3 + ADDR_W + 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              stall_i, flush_i;
    logic [DATA_W-1:0] rs_data_i, rt_data_i, imm_i;
    logic [ADDR_W-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
    logic              alu_src_i;
    logic [2:0]        alu_ctrl_i;
    logic              reg_dst_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
    logic              exmem_reg_write_i, memwb_reg_write_i;
    logic [ADDR_W-1:0] exmem_rd_i, memwb_rd_i;
    logic [DATA_W-1:0] exmem_data_i, memwb_data_i;
    logic [DATA_W-1:0] alu_data1_o, alu_data2_o, store_data_o;
    logic [2:0]        alu_ctrl_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, hazard_stall_o;

    int total = 0;
    int bad   = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_v;
    logic [OUT_W-1:0] obs;

    assign obs = {alu_data1_o, alu_data2_o, alu_ctrl_o, store_data_o, wr_addr_o,
                  reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o};

    id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .alu_src_i(alu_src_i), .alu_ctrl_i(alu_ctrl_i), .reg_dst_i(reg_dst_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_to_reg_i(mem_to_reg_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .store_data_o(store_data_o), .wr_addr_o(wr_addr_o), .reg_write_o(reg_write_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
        .hazard_stall_o(hazard_stall_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    function automatic logic [OUT_W-1:0] pack_exp(
        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2, input logic [2:0] ctrl,
        input logic [DATA_W-1:0] st, input logic [ADDR_W-1:0] wa,
        input logic rw, input logic mr, input logic mw, input logic m2r);
        return {d1, d2, ctrl, st, wa, rw, mr, mw, m2r};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(
        input logic [DATA_W-1:0] rs_d, input logic [DATA_W-1:0] rt_d, input logic [DATA_W-1:0] imm,
        input logic [ADDR_W-1:0] rs_a, input logic [ADDR_W-1:0] rt_a, input logic [ADDR_W-1:0] rd_a,
        input logic src, input logic [2:0] ctrl, input logic dst,
        input logic rw, input logic mr, input logic mw, input logic m2r);
        rs_data_i = rs_d; rt_data_i = rt_d; imm_i = imm;
        rs_addr_i = rs_a; rt_addr_i = rt_a; rd_addr_i = rd_a;
        alu_src_i = src; alu_ctrl_i = ctrl; reg_dst_i = dst;
        reg_write_i = rw; mem_read_i = mr; mem_write_i = mw; mem_to_reg_i = m2r;
    endtask

    task automatic fwd_off();
        exmem_reg_write_i = 1'b0; exmem_rd_i = '0; exmem_data_i = '0;
        memwb_reg_write_i = 1'b0; memwb_rd_i = '0; memwb_data_i = '0;
    endtask

    // scoreboard pop; returns all-X when empty so the comparison cannot pass
    task automatic sb_pop(output logic [OUT_W-1:0] v);
        if (exp_q.size() == 0) v = 'x;
        else v = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; fwd_off();
        set_id(32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd1, 5'd2, 5'd3, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        exp_q.push_back('0);
        tick(); tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_outputs: actual=%h required=%h", obs, exp_v); end
        total++;
        if (hazard_stall_o !== 1'b0) begin bad++; $display("FAIL reset_hazard: actual=%b required=0", hazard_stall_o); end
        set_id('0, '0, '0, '0, '0, '0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
    endtask

    task automatic test_capture();
        set_id(32'h5, 32'h3, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(pack_exp(32'h5, 32'h3, 3'b011, 32'h3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL capture: actual=%h required=%h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] rs_d, rt_d, imm;
        logic [ADDR_W-1:0] rs_a, rt_a, rd_a;
        logic src, dst, rw, mw;
        logic [2:0] ctrl;
        for (int i = 0; i < 8; i++) begin
            rs_d = $urandom; rt_d = $urandom; imm = $urandom;
            rs_a = 5'($urandom_range(0, 31)); rt_a = 5'($urandom_range(0, 31)); rd_a = 5'($urandom_range(0, 31));
            src = 1'($urandom_range(0, 1)); dst = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1));
            ctrl = 3'($urandom_range(0, 3));
            set_id(rs_d, rt_d, imm, rs_a, rt_a, rd_a, src, ctrl, dst, rw, 1'b0, mw, 1'b0);
            exp_q.push_back(pack_exp(rs_d, src ? imm : rt_d, ctrl, rt_d, dst ? rd_a : rt_a,
                                     rw, 1'b0, mw, 1'b0));
            tick();
            sb_pop(exp_v); total++;
            if (obs !== exp_v) begin bad++; $display("FAIL back_to_back[%0d]: actual=%h required=%h", i, obs, exp_v); end
        end
    endtask

    task automatic test_forward();
        set_id(32'hAA, 32'hBB, 32'h0, 5'd5, 5'd6, 5'd7, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(pack_exp(32'hAA, 32'hBB, 3'b010, 32'hBB, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL fwd_none: actual=%h required=%h", obs, exp_v); end
        exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd5; exmem_data_i = 32'h11;
        memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd5; memwb_data_i = 32'h22;
        #1; total++;
        if (alu_data1_o !== 32'h11) begin bad++; $display("FAIL fwd_exmem_priority: actual=%h required=%h", alu_data1_o, 32'h11); end
        exmem_reg_write_i = 1'b0;
        #1; total++;
        if (alu_data1_o !== 32'h22) begin bad++; $display("FAIL fwd_memwb: actual=%h required=%h", alu_data1_o, 32'h22); end
        exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd6; exmem_data_i = 32'h33; memwb_reg_write_i = 1'b0;
        #1; total++;
        if ({alu_data1_o, alu_data2_o, store_data_o} !== {32'hAA, 32'h33, 32'h33}) begin
            bad++; $display("FAIL fwd_rt: actual=%h/%h/%h required=aa/33/33", alu_data1_o, alu_data2_o, store_data_o);
        end
        fwd_off();
    endtask

    task automatic test_zero_reg();
        set_id(32'h77, 32'h66, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(pack_exp(32'h77, 32'h66, 3'b001, 32'h66, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL zero_capture: actual=%h required=%h", obs, exp_v); end
        exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd0; exmem_data_i = 32'hFF;
        memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd0; memwb_data_i = 32'hEE;
        #1; total++;
        if ({alu_data1_o, store_data_o} !== {32'h77, 32'h66}) begin
            bad++; $display("FAIL zero_no_forward: actual=%h/%h required=77/66", alu_data1_o, store_data_o);
        end
        fwd_off();
        // load targeting $0
        set_id(32'h1, 32'h2, 32'h0, 5'd3, 5'd0, 5'd9, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(pack_exp(32'h1, 32'h0, 3'b010, 32'h2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1));
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL zero_load_capture: actual=%h required=%h", obs, exp_v); end
        set_id(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; total++;
        if (hazard_stall_o !== 1'b0) begin bad++; $display("FAIL zero_load_hazard: actual=%b required=0", hazard_stall_o); end
    endtask

    task automatic test_load_use();
        set_id(32'h10, 32'h20, 32'h4, 5'd1, 5'd8, 5'd0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(pack_exp(32'h10, 32'h4, 3'b010, 32'h20, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1));
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lw_capture: actual=%h required=%h", obs, exp_v); end
        set_id(32'h30, 32'h40, 32'h0, 5'd8, 5'd9, 5'd10, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; total++;
        if (hazard_stall_o !== 1'b1) begin bad++; $display("FAIL lw_hazard_rs: actual=%b required=1", hazard_stall_o); end
        exp_q.push_back('0);
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lw_bubble: actual=%h required=%h", obs, exp_v); end
        total++;
        if (hazard_stall_o !== 1'b0) begin bad++; $display("FAIL lw_hazard_drop: actual=%b required=0", hazard_stall_o); end
        exp_q.push_back(pack_exp(32'h30, 32'h40, 3'b010, 32'h40, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lw_dependent: actual=%h required=%h", obs, exp_v); end
        // second load, dependency through rt only
        set_id(32'h0, 32'h0, 32'h8, 5'd2, 5'd12, 5'd0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(pack_exp(32'h0, 32'h8, 3'b010, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1));
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lw2_capture: actual=%h required=%h", obs, exp_v); end
        set_id(32'h1, 32'h2, 32'h0, 5'd3, 5'd12, 5'd13, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; total++;
        if (hazard_stall_o !== 1'b1) begin bad++; $display("FAIL lw_hazard_rt: actual=%b required=1", hazard_stall_o); end
        set_id(32'h1, 32'h2, 32'h0, 5'd3, 5'd4, 5'd13, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; total++;
        if (hazard_stall_o !== 1'b0) begin bad++; $display("FAIL lw_no_dep: actual=%b required=0", hazard_stall_o); end
    endtask

    task automatic test_hold_flush();
        logic [OUT_W-1:0] a_exp;
        a_exp = pack_exp(32'h1234, 32'h8, 3'b010, 32'h5678, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        set_id(32'h1234, 32'h5678, 32'h8, 5'd2, 5'd3, 5'd4, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(a_exp);
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL store_capture: actual=%h required=%h", obs, exp_v); end
        stall_i = 1'b1;
        set_id(32'h9999, 32'h8888, 32'h7777, 5'd11, 5'd12, 5'd13, 1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(a_exp);
            tick();
            sb_pop(exp_v); total++;
            if (obs !== exp_v) begin bad++; $display("FAIL stall_hold[%0d]: actual=%h required=%h", i, obs, exp_v); end
        end
        stall_i = 1'b0; flush_i = 1'b1;
        exp_q.push_back('0);
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL flush_bubble: actual=%h required=%h", obs, exp_v); end
        flush_i = 1'b0;
        set_id(32'h1234, 32'h5678, 32'h8, 5'd2, 5'd3, 5'd4, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(a_exp);
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL recapture: actual=%h required=%h", obs, exp_v); end
        stall_i = 1'b1; flush_i = 1'b1;
        set_id(32'h9999, 32'h8888, 32'h7777, 5'd11, 5'd12, 5'd13, 1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(a_exp);
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL stall_over_flush: actual=%h required=%h", obs, exp_v); end
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_imm_reset();
        set_id(32'h21, 32'h33, 32'hFFFF_FFFC, 5'd1, 5'd4, 5'd7, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(pack_exp(32'h21, 32'hFFFF_FFFC, 3'b010, 32'h33, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        sb_pop(exp_v); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL imm_capture: actual=%h required=%h", obs, exp_v); end
        exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd4; exmem_data_i = 32'hDEAD;
        #1; total++;
        if ({alu_data2_o, store_data_o} !== {32'hFFFF_FFFC, 32'hDEAD}) begin
            bad++; $display("FAIL imm_fwd_store: actual=%h/%h required=fffffffc/0000dead", alu_data2_o, store_data_o);
        end
        #2;
        rst_i = 1'b0;
        #1;
        exp_q.push_back('0);
        sb_pop(exp_v); total++;
        if (obs !== exp_v || hazard_stall_o !== 1'b0) begin
            bad++; $display("FAIL async_reset: actual=%h hz=%b required=%h hz=0", obs, hazard_stall_o, exp_v);
        end
        fwd_off();
        tick();
        rst_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_back_to_back();
        test_forward();
        test_zero_reg();
        test_load_use();
        test_hold_flush();
        test_imm_reset();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: actual=%0d left required=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
